// File: rtl/mem_mp.sv
// Parametrised N-port byte-addressed memory with per-port wait states,
// read-latency pipeline, read-only protection and fixed collision priority.
module mem_mp #(
    parameter int unsigned   PN        = 2,
    parameter int unsigned   DW        = 32,
    parameter int unsigned   AW        = 32,
    parameter int unsigned   SZ        = 2**12,
    parameter int unsigned   LAT       = 1,
    parameter int unsigned   WS [PN]   = '{default: 0},
    parameter logic [PN-1:0] RO        = '0,
    parameter string         FN        = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PN-1:0]         vld,
    input  logic [PN-1:0]         wen,
    input  logic [PN*AW-1:0]      adr,
    input  logic [PN*(DW/8)-1:0]  ben,
    input  logic [PN*DW-1:0]      wdt,
    output logic [PN-1:0]         rdy,
    output logic [PN*DW-1:0]      rdt,
    output logic [PN-1:0]         rvl,
    output logic [PN-1:0]         err
);

    localparam int unsigned BW  = DW / 8;
    localparam int unsigned MAW = $clog2(SZ);

    // Only the low MAW address bits select a byte; FN is reserved for a
    // simulation-only preload and has no effect on the logic.
    localparam bit unused_fn = (FN != "");
    logic unused_adr;
    assign unused_adr = ^adr;

    logic [7:0] mem [SZ];

    // Byte lane b of a request targets (adr + b) mod SZ, so accesses wrap.
    function automatic logic [MAW-1:0] lane_addr(input logic [AW-1:0] a, input int b);
        return a[MAW-1:0] + MAW'(b);
    endfunction

    // Ports are visited from highest to lowest index so that the lowest
    // port's nonblocking update to a shared byte lands last and wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = int'(PN) - 1; p >= 0; p--) begin
                if (vld[p] && rdy[p] && wen[p] && !RO[p]) begin
                    for (int b = 0; b < int'(BW); b++) begin
                        if (ben[p*BW + b]) begin
                            mem[lane_addr(adr[p*AW +: AW], b)] <= wdt[p*DW + 8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < int'(PN); p++) begin : g_port
        logic [3:0]    cnt;
        logic [DW-1:0] smp;
        logic [LAT-1:0] pv;
        logic [DW-1:0] pd [LAT];
        logic          err_q;
        logic          xfer;

        assign rdy[p] = (cnt == 4'(WS[p]));
        assign xfer   = vld[p] & rdy[p];

        // Sampled before this edge's writes commit, giving read-first data.
        always_comb begin
            smp = '0;
            for (int b = 0; b < int'(BW); b++) begin
                if (ben[p*BW + b]) begin
                    smp[8*b +: 8] = mem[lane_addr(adr[p*AW +: AW], b)];
                end
            end
        end

        // Data stages only advance with a valid token, so the last stage
        // holds the previous read result while rvl is low.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt   <= '0;
                pv    <= '0;
                err_q <= 1'b0;
                for (int s = 0; s < int'(LAT); s++) begin
                    pd[s] <= '0;
                end
            end else begin
                if (!vld[p] || rdy[p]) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                err_q <= xfer & wen[p] & RO[p];
                pv[0] <= xfer & ~wen[p];
                if (xfer && !wen[p]) begin
                    pd[0] <= smp;
                end
                for (int s = 1; s < int'(LAT); s++) begin
                    pv[s] <= pv[s-1];
                    if (pv[s-1]) begin
                        pd[s] <= pd[s-1];
                    end
                end
            end
        end

        assign rvl[p]           = pv[LAT-1];
        assign rdt[p*DW +: DW]  = pd[LAT-1];
        assign err[p]           = err_q;
    end

endmodule

// File: tb/tb_mem_mp.sv
// Bench for mem_mp: directed vector table and random traffic against a byte
// array model on a LAT=1 instance, plus wait/RO/reset sequences on a LAT=3 one.
module tb_mem_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_rst, b_rst;
    logic [1:0]  a_vld, a_wen, a_rdy, a_rvl, a_err;
    logic [1:0]  b_vld, b_wen, b_rdy, b_rvl, b_err;
    logic [63:0] a_adr, a_wdt, a_rdt, b_adr, b_wdt, b_rdt;
    logic [7:0]  a_ben, b_ben;

    mem_mp #(.PN(2), .DW(32), .AW(32), .SZ(4096), .LAT(1), .WS('{0, 0}),
             .RO(2'b00), .FN("")) dut_a (
        .clk(clk), .rst(a_rst), .vld(a_vld), .wen(a_wen), .adr(a_adr),
        .ben(a_ben), .wdt(a_wdt), .rdy(a_rdy), .rdt(a_rdt), .rvl(a_rvl), .err(a_err)
    );

    mem_mp #(.PN(2), .DW(32), .AW(32), .SZ(4096), .LAT(3), .WS('{0, 2}),
             .RO(2'b10), .FN("")) dut_b (
        .clk(clk), .rst(b_rst), .vld(b_vld), .wen(b_wen), .adr(b_adr),
        .ben(b_ben), .wdt(b_wdt), .rdy(b_rdy), .rdt(b_rdt), .rvl(b_rvl), .err(b_err)
    );

    typedef struct {
        logic [1:0]  vld, wen;
        logic [31:0] adr0, adr1;
        logic [3:0]  ben0, ben1;
        logic [31:0] wdt0, wdt1;
        logic [1:0]  exp_rvl;
        logic [31:0] exp_rdt0, exp_rdt1;
    } vec_t;

    vec_t vecs [10];

    logic [7:0]  mdl [4096];
    logic [31:0] m_rdt [2];
    logic [1:0]  m_rvl;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_vld = v.vld;
        a_wen = v.wen;
        a_adr = {v.adr1, v.adr0};
        a_ben = {v.ben1, v.ben0};
        a_wdt = {v.wdt1, v.wdt0};
    endtask

    // Entered and left on a falling edge: check last cycle's prediction,
    // drive a random request pair, then advance the byte-array model.
    task automatic randomStep();
        logic [1:0]  v, w;
        logic [31:0] ad [2];
        logic [3:0]  be [2];
        logic [31:0] d [2];
        logic [31:0] rd;
        int          addr;
        bit          taken [int];
        checkOutput("rand rvl", 64'(a_rvl), 64'(m_rvl));
        checkOutput("rand rdt0", 64'(a_rdt[31:0]), 64'(m_rdt[0]));
        checkOutput("rand rdt1", 64'(a_rdt[63:32]), 64'(m_rdt[1]));
        checkOutput("rand rdy", 64'(a_rdy), 64'h3);
        for (int p = 0; p < 2; p++) begin
            v[p]  = 1'($urandom_range(0, 1));
            w[p]  = 1'($urandom_range(0, 1));
            ad[p] = 32'h400 + 32'($urandom_range(0, 252));
            be[p] = 4'($urandom);
            d[p]  = $urandom;
        end
        a_vld = v;
        a_wen = w;
        a_adr = {ad[1], ad[0]};
        a_ben = {be[1], be[0]};
        a_wdt = {d[1], d[0]};
        for (int p = 0; p < 2; p++) begin
            if (v[p] && !w[p]) begin
                rd = '0;
                for (int b = 0; b < 4; b++) begin
                    if (be[p][b]) rd[8*b +: 8] = mdl[(int'(ad[p]) + b) % 4096];
                end
                m_rdt[p] = rd;
                m_rvl[p] = 1'b1;
            end else begin
                m_rvl[p] = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (v[p] && w[p]) begin
                for (int b = 0; b < 4; b++) begin
                    addr = (int'(ad[p]) + b) % 4096;
                    if (be[p][b] && !taken.exists(addr)) begin
                        mdl[addr]   = d[p][8*b +: 8];
                        taken[addr] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // One bounded request on instance B; returns on the falling edge that
    // follows the transfer edge, with vld already dropped.
    task automatic bReq(input int p, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        b_vld[p]          = 1'b1;
        b_wen[p]          = w;
        b_adr[p*32 +: 32] = a;
        b_ben[p*4 +: 4]   = be;
        b_wdt[p*32 +: 32] = d;
        while (b_rdy[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b req rdy", 64'(b_rdy[p]), 64'h1);
        @(negedge clk);
        b_vld[p] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 2'b01, 32'h100, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 32'h0};
        vecs[1] = '{2'b01, 2'b00, 32'h100, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0};
        vecs[2] = '{2'b11, 2'b11, 32'h200, 32'h200, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2'b01, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{2'b11, 2'b01, 32'h200, 32'h200, 4'hF, 4'hF, 32'h33333333, 32'h0, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[4] = '{2'b10, 2'b00, 32'h0, 32'h200, 4'h0, 4'hF, 32'h0, 32'h0, 2'b10, 32'hDEADBEEF, 32'h11111111};
        vecs[5] = '{2'b01, 2'b01, 32'hFFE, 32'h0, 4'hF, 4'h0, 32'h44332211, 32'h0, 2'b10, 32'hDEADBEEF, 32'h33333333};
        vecs[6] = '{2'b11, 2'b00, 32'hFFE, 32'h000, 4'h3, 4'h3, 32'h0, 32'h0, 2'b00, 32'hDEADBEEF, 32'h33333333};
        vecs[7] = '{2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 32'h00002211, 32'h00004433};
        vecs[8] = '{2'b01, 2'b00, 32'hFFF, 32'h0, 4'h7, 4'h0, 32'h0, 32'h0, 2'b00, 32'h00002211, 32'h00004433};
        vecs[9] = '{2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h00443322, 32'h00004433};

        a_rst = 1'b1; b_rst = 1'b1;
        a_vld = '0; a_wen = '0; a_adr = '0; a_ben = '0; a_wdt = '0;
        b_vld = '0; b_wen = '0; b_adr = '0; b_ben = '0; b_wdt = '0;
        repeat (2) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;

        checkOutput("a reset rvl", 64'(a_rvl), 64'h0);
        checkOutput("a reset err", 64'(a_err), 64'h0);
        checkOutput("a reset rdt", a_rdt, 64'h0);
        checkOutput("a reset rdy", 64'(a_rdy), 64'h3);
        checkOutput("b reset rvl", 64'(b_rvl), 64'h0);
        checkOutput("b reset rdt", b_rdt, 64'h0);
        checkOutput("b reset rdy", 64'(b_rdy), 64'h1);

        // Directed vectors: each row checks the outcome of the previous row.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("vec%0d rvl", i), 64'(a_rvl), 64'(vecs[i].exp_rvl));
            checkOutput($sformatf("vec%0d rdt0", i), 64'(a_rdt[31:0]), 64'(vecs[i].exp_rdt0));
            checkOutput($sformatf("vec%0d rdt1", i), 64'(a_rdt[63:32]), 64'(vecs[i].exp_rdt1));
            checkOutput($sformatf("vec%0d rdy", i), 64'(a_rdy), 64'h3);
            applyStimulus(vecs[i]);
        end

        m_rdt[0] = 32'h00443322;
        m_rdt[1] = 32'h00004433;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a_vld = 2'b01; a_wen = 2'b01; a_ben = 8'h0F;
            a_adr = {32'h0, 32'h400 + 32'(4*i)};
            a_wdt = {32'h0, $urandom};
            for (int b = 0; b < 4; b++) mdl[16'h400 + 4*i + b] = a_wdt[8*b +: 8];
        end
        @(negedge clk);
        a_vld = '0;
        @(negedge clk);
        m_rvl = 2'b00;
        for (int i = 0; i < 300; i++) randomStep();
        checkOutput("rand final rvl", 64'(a_rvl), 64'(m_rvl));
        checkOutput("rand final rdt", a_rdt, {m_rdt[1], m_rdt[0]});
        a_vld = '0;

        // Wait states on port 1 (WS=2) and LAT=3 read latency.
        bReq(0, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D);
        b_vld[1] = 1'b1; b_wen[1] = 1'b0; b_adr[63:32] = 32'h100; b_ben[7:4] = 4'hF;
        checkOutput("b ws wait0", 64'(b_rdy[1]), 64'h0);
        @(negedge clk);
        checkOutput("b ws wait1", 64'(b_rdy[1]), 64'h0);
        @(negedge clk);
        checkOutput("b ws ready", 64'(b_rdy[1]), 64'h1);
        @(negedge clk);
        b_vld[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("b lat rvl k%0d", k), 64'(b_rvl[1]), 64'(k == 3));
            if (k == 3) checkOutput("b lat rdt1", 64'(b_rdt[63:32]), 64'hCAFEF00D);
            @(negedge clk);
        end
        b_vld[1] = 1'b1;
        checkOutput("b abandon wait0", 64'(b_rdy[1]), 64'h0);
        @(negedge clk);
        checkOutput("b abandon wait1", 64'(b_rdy[1]), 64'h0);
        b_vld[1] = 1'b0;
        @(negedge clk);
        b_vld[1] = 1'b1;
        checkOutput("b restart wait0", 64'(b_rdy[1]), 64'h0);
        @(negedge clk);
        checkOutput("b restart wait1", 64'(b_rdy[1]), 64'h0);
        @(negedge clk);
        checkOutput("b restart ready", 64'(b_rdy[1]), 64'h1);
        @(negedge clk);
        b_vld[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Read-only port 1: write is dropped and flagged for one cycle.
        bReq(0, 1'b1, 32'h300, 4'hF, 32'h5A5A5A5A);
        bReq(1, 1'b1, 32'h300, 4'hF, 32'hAAAAAAAA);
        checkOutput("b ro err pulse", 64'(b_err), 64'h2);
        checkOutput("b ro no rvl", 64'(b_rvl), 64'h0);
        @(negedge clk);
        checkOutput("b ro err clear", 64'(b_err), 64'h0);
        bReq(1, 1'b0, 32'h300, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("b ro readback rvl", 64'(b_rvl), 64'h2);
        checkOutput("b ro readback rdt", 64'(b_rdt[63:32]), 64'h5A5A5A5A);

        // Reset with reads in flight: nothing emerges and memory survives.
        @(negedge clk);
        b_vld[0] = 1'b1; b_wen[0] = 1'b0; b_adr[31:0] = 32'h100; b_ben[3:0] = 4'hF;
        @(negedge clk);
        b_adr[31:0] = 32'h300;
        @(negedge clk);
        b_adr[31:0] = 32'h100;
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        b_vld = '0;
        checkOutput("b rst rdy", 64'(b_rdy), 64'h1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("b rst rvl k%0d", k), 64'(b_rvl), 64'h0);
            checkOutput($sformatf("b rst rdt k%0d", k), b_rdt, 64'h0);
            @(negedge clk);
        end
        bReq(0, 1'b0, 32'h100, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("b post rst rvl a", 64'(b_rvl), 64'h1);
        checkOutput("b post rst 0x100", 64'(b_rdt[31:0]), 64'hCAFEF00D);
        bReq(0, 1'b0, 32'h300, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("b post rst rvl b", 64'(b_rvl), 64'h1);
        checkOutput("b post rst 0x300", 64'(b_rdt[31:0]), 64'h5A5A5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_mp.md
Name: mem_mp

Overview:
- Parametrised N-port byte-addressed memory model for the r5p testbench. It is the successor to the fixed two-port (fetch + load/store) model.
- Adds the following over that model:
  - configurable port count;
  - configurable data width;
  - read latency pipeline with a read-valid strobe;
  - per-port wait-state insertion on rdy;
  - per-port read-only protection with an error strobe;
  - deterministic same-cycle collision rules.
- Sits between CPU/DMA bus masters and the backing array in simulation tops. It is also synthesizable for FPGA smoke tests when FN="".

Parameters:
- PN, 2, number of ports (1..8)
- DW, 32, data width in bits (32 or 64); BW=DW/8 byte lanes
- AW, 32, address width
- SZ, 2**12, memory size in bytes; power of two
- LAT, 1, read latency in cycles (1..4)
- WS, '{default:0}, per-port wait states before rdy (0..15)
- RO, '0, PN-bit mask; bit p=1 makes port p read-only
- FN, "", binary init file loaded at time 0 (simulation only)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- vld  input  PN  request valid per port
- wen  input  PN  1=write, 0=read
- adr  input  PN*AW  byte address, port p at [p*AW+:AW]
- ben  input  PN*BW  byte enables
- wdt  input  PN*DW  write data
- rdy  output  PN  request accepted this cycle when vld&rdy
- rdt  output  PN*DW  read data
- rvl  output  PN  rdt valid strobe
- err  output  PN  write to read-only port strobe

Behaviour:
- Clock and reset:
  - Single clock domain, synchronous active-high reset.
  - Reset has priority over every other event.
- Reset values:
  - rdt=0, rvl=0, err=0.
  - All wait counters=0 and read pipelines flushed.
  - The memory array is NOT reset; it retains its contents.
- Transfer: occurs on port p when vld[p]&rdy[p] at the rising edge of clk.
- Wait states (per-port counter cnt, 4 bits):
  - rdy[p] = (cnt==WS[p]), combinational from cnt only.
  - vld[p]&!rdy[p]: cnt increments.
  - Transfer: cnt returns to 0.
  - !vld[p]: cnt clears to 0, so an abandoned request restarts its wait.
  - WS[p]=0 gives rdy tied high and back-to-back transfers every cycle.
- Addressing:
  - Lane b of port p accesses byte (adr+b) mod SZ, i.e. the address is masked to log2(SZ) bits.
  - Wrap-around at the top of memory is legal; unaligned addresses are legal.
- Write:
  - Bytes with ben[b]=1 are updated at the transfer edge.
  - No rvl is generated for writes.
- Read-only:
  - A write transfer on a port with RO[p]=1 leaves memory unchanged.
  - err[p]=1 for exactly one cycle after the transfer; rvl stays 0.
- Read:
  - Data is sampled from the array at the transfer edge (read-first).
  - It is presented on rdt with rvl[p]=1 exactly LAT cycles after the transfer edge; LAT=1 gives data in the next cycle.
  - Lanes with ben[b]=0 drive 0 (not x).
  - rdt holds its last value while rvl=0.
  - The pipeline is fully pipelined, so back-to-back reads yield back-to-back rvl.
- Collisions:
  - Same-cycle writes from several ports to the same byte: the lowest port index wins.
  - Same-cycle read and write to the same byte: the read returns the old value.
- Reset mid-operation:
  - In-flight reads are discarded; rvl=0 from the first cycle after the reset edge.
  - Wait counters restart.
  - Writes transferred before reset are retained.
- FN load: when FN is non-empty, bytes from the file are loaded from address 0 at time 0; the remainder of the array stays x.

Test Plan:
1. PN=2, WS=0, LAT=1: port0 writes 0xDEADBEEF at 0x100 with ben=4'hF, then reads 0x100 → rdy=1 every cycle; rvl[0]=1 one cycle after the read transfer with rdt=0xDEADBEEF.
2. LAT=3, WS[1]=2: port1 holds vld with a read at 0x100 → rdy[1] low for 2 cycles and high on the 3rd; rvl[1] asserts 3 cycles after the transfer. vld dropped after 1 wait cycle → the counter restarts (2 more waits on reassertion).
3. Collision: port0 and port1 both write 0x200 (0x11111111 / 0x22222222) in the same cycle, and port1 reads 0x200 next → rdt=0x11111111. Simultaneous read of 0x200 on port1 while port0 writes 0x33 → the old value is returned.
4. RO=2'b10: port1 writes 0xAAAAAAAA at 0x300 → err[1] pulses 1 cycle, rvl[1]=0; a subsequent read of 0x300 returns the prior contents.
5. Wrap: SZ=4096, write at 0xFFE with ben=4'hF, data 0x44332211 → bytes 0xFFE=0x11, 0xFFF=0x22, 0x000=0x33, 0x001=0x44. Partial read with ben=4'b0011 at 0xFFE → rdt=0x00002211.
6. LAT=4: issue 3 back-to-back reads, assert rst for 1 cycle after the 2nd transfer → no rvl for any in-flight read; rdt=0; memory contents unchanged afterward.
